add16_seq: RTL

ADD16_SEQ -- requirements
Module: add16_seq

---
 rtl/add16_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/add16_seq.sv
// add16_seq: multi-cycle W-bit adder/subtractor that reuses one external
// 4-bit adder (adder4), processing one nibble per clock from LSB to MSB.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               operation request (accepted in IDLE or DONE only)
//   op_a, op_b          W-bit operands, sampled with start
//   cin                 carry-in, sampled with start
//   sub                 1 selects op_a - op_b, sampled with start
//   nib_a, nib_b        current nibble driven to adder4 a/b (0 outside ADD)
//   nib_cin             carry driven to adder4 cin (0 outside ADD)
//   nib_s, nib_cout     adder4 sum and carry-out (combinational from nib_*)
//   busy                high in the ADD state
//   done                one-cycle pulse, high in the DONE state
//   sum, cout           result, held until the next accepted start
module add16_seq #(
  parameter int unsigned N_NIB = 4,
  localparam int unsigned W    = 4 * N_NIB
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  input  logic         sub,
  output logic [3:0]   nib_a,
  output logic [3:0]   nib_b,
  output logic         nib_cin,
  input  logic [3:0]   nib_s,
  input  logic         nib_cout,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned IW = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(N_NIB - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state_q)
        StAdd: begin
          // start is deliberately ignored here
          sum[4*idx_q +: 4] <= nib_s;
          carry_q           <= nib_cout;
          if (idx_q == LastIdx) begin
            cout    <= nib_cout;
            idx_q   <= '0;
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept start; DONE otherwise falls back to IDLE
          if (start) begin
            a_q     <= op_a;
            // Subtraction as a + ~b + 1
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            state_q <= StAdd;
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign busy = (state_q == StAdd);
  assign done = (state_q == StDone);

  // Nibble mux must be combinational so adder4 settles within the ADD cycle
  always_comb begin
    nib_a   = 4'h0;
    nib_b   = 4'h0;
    nib_cin = 1'b0;
    if (state_q == StAdd) begin
      nib_a   = a_q[4*idx_q +: 4];
      nib_b   = b_q[4*idx_q +: 4];
      nib_cin = carry_q;
    end
  end

endmodule
